// File: rtl/ifetch.sv
// Instruction fetch unit: holds the PC and IR and issues one registered
// read request to instruction memory per fetch, with absolute/relative branch loading.
module ifetch #(
   parameter logic [15:0] PC_RESET = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_f,
   input  logic        fetch,
   input  logic        pc_load,
   input  logic        br_sel,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   output logic [31:0] ir,
   output logic        ir_valid,
   output logic [15:0] pc,
   output logic        busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic        ir_valid_q, ir_valid_d;
   logic        imem_req_q, imem_req_d;
   logic [15:0] imem_addr_q, imem_addr_d;

   logic [15:0] br_target;
   logic [15:0] pc_idle;

   // Branch target uses the IR contents held from the last completed fetch.
   always_comb begin
      br_target = br_sel ? (pc_q + ir_q[15:0]) : ir_q[15:0];
      pc_idle   = pc_load ? br_target : pc_q;
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      ir_valid_d  = 1'b0;
      imem_req_d  = imem_req_q;
      imem_addr_d = imem_addr_q;
      case (state_q)
         IDLE: begin
            pc_d = pc_idle;
            if (fetch) begin
               state_d     = FETCH;
               imem_req_d  = 1'b1;
               imem_addr_d = pc_idle;
            end
         end
         FETCH: begin
            // Request and address are frozen until the ack is sampled.
            if (imem_ack) begin
               state_d    = IDLE;
               ir_d       = imem_rdata;
               pc_d       = pc_q + 16'd1;
               ir_valid_d = 1'b1;
               imem_req_d = 1'b0;
            end
         end
         default: begin
            state_d    = IDLE;
            imem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q     <= IDLE;
         pc_q        <= PC_RESET;
         ir_q        <= 32'h0;
         ir_valid_q  <= 1'b0;
         imem_req_q  <= 1'b0;
         imem_addr_q <= PC_RESET;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         ir_valid_q  <= ir_valid_d;
         imem_req_q  <= imem_req_d;
         imem_addr_q <= imem_addr_d;
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = imem_addr_q;
   assign ir        = ir_q;
   assign ir_valid  = ir_valid_q;
   assign pc        = pc_q;
   assign busy      = (state_q == FETCH);

endmodule
